// File: rtl/cr_xp10_decomp_blk_stats.sv
// XP10 decompressor block-type / stall statistics.
// Saturating event counters with a snapshot shadow bank streamed out over valid/ready.
module cr_xp10_decomp_blk_stats #(
  parameter int N_EVT = 35,
  parameter int CNT_W = 32,
  parameter bit CLR_ON_SNAP = 1'b1,
  localparam int IDX_W = $clog2(N_EVT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EVT-1:0] evt_stb,
  input  logic             snap_req,
  output logic             snap_busy,
  output logic             snap_drop,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             rd_sat,
  output logic             rd_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_EVT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  logic [CNT_W-1:0] cnt [N_EVT];
  logic [N_EVT-1:0] sat;
  logic [CNT_W:0]   shadow [N_EVT];
  logic [CNT_W:0]   ent;

  logic accept;
  logic fin;
  logic capture;

  // A request is honoured when idle or on the very edge the last beat leaves.
  always_comb begin
    accept  = (state_q == DRAIN) && rd_ready;
    fin     = accept && (idx_q == LAST);
    capture = snap_req && ((state_q == IDLE) || fin);
  end

  // FSM state and readout index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: capture starts a drain, each accepted beat advances the index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (fin) begin
          state_d = capture ? DRAIN : IDLE;
          idx_d   = '0;
        end else if (accept) begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // Live counters: count, hold at all-ones and flag the lost event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_EVT; i++) begin
        cnt[i] <= '0;
      end
      sat <= '0;
    end else begin
      for (int i = 0; i < N_EVT; i++) begin
        if (capture && CLR_ON_SNAP) begin
          cnt[i] <= CNT_W'(evt_stb[i]);
          sat[i] <= 1'b0;
        end else if (evt_stb[i]) begin
          if (&cnt[i]) begin
            sat[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Shadow bank takes the pre-edge counter values, so capture-cycle events stay live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_EVT; i++) begin
        shadow[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < N_EVT; i++) begin
        shadow[i] <= {sat[i], cnt[i]};
      end
    end
  end

  // Readout outputs depend only on registered state, so they hold while stalled.
  always_comb begin
    ent       = shadow[idx_q];
    rd_valid  = (state_q == DRAIN);
    snap_busy = (state_q == DRAIN);
    snap_drop = snap_req && (state_q == DRAIN) && !fin;
    rd_idx    = idx_q;
    rd_cnt    = ent[CNT_W-1:0];
    rd_sat    = ent[CNT_W];
    rd_last   = (state_q == DRAIN) && (idx_q == LAST);
  end

endmodule

// File: tb/tb_cr_xp10_decomp_blk_stats.sv
// Bench for cr_xp10_decomp_blk_stats: a 32-bit and a 4-bit instance share stimulus;
// a scoreboard queue holds the expected beats of each snapshot.
module tb_cr_xp10_decomp_blk_stats;
  localparam int N  = 35;
  localparam int IW = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] evt_stb;
  logic         snap_req;
  logic         rd_ready;

  logic          a_busy, a_drop, a_valid, a_sat, a_last;
  logic [IW-1:0] a_idx;
  logic [31:0]   a_cnt;
  logic          b_busy, b_drop, b_valid, b_sat, b_last;
  logic [IW-1:0] b_idx;
  logic [3:0]    b_cnt;

  cr_xp10_decomp_blk_stats #(.N_EVT(N), .CNT_W(32), .CLR_ON_SNAP(1'b1)) u_a (
    .clk(clk), .rst(rst), .evt_stb(evt_stb), .snap_req(snap_req),
    .snap_busy(a_busy), .snap_drop(a_drop), .rd_valid(a_valid),
    .rd_ready(rd_ready), .rd_idx(a_idx), .rd_cnt(a_cnt),
    .rd_sat(a_sat), .rd_last(a_last)
  );

  cr_xp10_decomp_blk_stats #(.N_EVT(N), .CNT_W(4), .CLR_ON_SNAP(1'b1)) u_b (
    .clk(clk), .rst(rst), .evt_stb(evt_stb), .snap_req(snap_req),
    .snap_busy(b_busy), .snap_drop(b_drop), .rd_valid(b_valid),
    .rd_ready(rd_ready), .rd_idx(b_idx), .rd_cnt(b_cnt),
    .rd_sat(b_sat), .rd_last(b_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [31:0] ca;
    logic [3:0]  cb;
    logic        sb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ma [N];
  logic [3:0]  mb [N];
  logic        msb [N];
  bit          busy;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      msb[i] = 1'b0;
    end
  endtask

  // One clock: check outputs at the falling edge, update the model, step past the edge.
  task automatic tick();
    bit fin;
    bit cap;
    @(negedge clk);
    if (rst) begin
      clear_model();
      @(posedge clk);
      #1;
      return;
    end
    chk("valid_a", a_valid, busy);
    chk("busy_a", a_busy, busy);
    chk("valid_b", b_valid, busy);
    chk("busy_b", b_busy, busy);
    fin = 1'b0;
    if (busy && q.size() > 0) begin
      chk("idx_a", a_idx, q[0].idx);
      chk("cnt_a", a_cnt, q[0].ca);
      chk("sat_a", a_sat, 1'b0);
      chk("last_a", a_last, q[0].idx == N - 1);
      chk("idx_b", b_idx, q[0].idx);
      chk("cnt_b", b_cnt, q[0].cb);
      chk("sat_b", b_sat, q[0].sb);
      chk("last_b", b_last, q[0].idx == N - 1);
      if (rd_ready) begin
        fin = (q.size() == 1);
        void'(q.pop_front());
      end
    end
    cap = snap_req && (!busy || fin);
    chk("drop_a", a_drop, snap_req && busy && !fin);
    chk("drop_b", b_drop, snap_req && busy && !fin);
    if (cap) begin
      for (int i = 0; i < N; i++) begin
        q.push_back('{i, ma[i], mb[i], msb[i]});
        ma[i] = '0;
        mb[i] = '0;
        msb[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (evt_stb[i]) begin
        ma[i] = ma[i] + 1;
        if (mb[i] == 4'hf) msb[i] = 1'b1;
        else mb[i] = mb[i] + 1'b1;
      end
    end
    if (cap) busy = 1'b1;
    else if (fin) busy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(int bitn, int n);
    for (int k = 0; k < n; k++) begin
      evt_stb = '0;
      evt_stb[bitn] = 1'b1;
      tick();
    end
    evt_stb = '0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  // Drain with optional random backpressure, a request at beat drop_at,
  // or a request on the last accepted beat (returns right after it).
  task automatic drain(bit rnd, int drop_at, bit snap_last);
    bit dropped = 1'b0;
    int budget = 0;
    while (busy && budget < 600) begin
      budget++;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      snap_req = 1'b0;
      if (!dropped && drop_at >= 0 && (N - q.size()) == drop_at) begin
        snap_req = 1'b1;
        dropped = 1'b1;
      end
      if (snap_last && q.size() == 1 && rd_ready) begin
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        rd_ready = 1'b1;
        return;
      end
      tick();
    end
    snap_req = 1'b0;
    rd_ready = 1'b1;
    chk("drain_done", a_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    evt_stb = '0;
    snap_req = 1'b0;
    rd_ready = 1'b1;
    clear_model();
    #2;
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_drop", a_drop, 1'b0);
    chk("rst_last", a_last, 1'b0);
    chk("rst_idx", a_idx, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Counting: bit0 x5, bit34 x3, then a clean follow-up snapshot.
    pulse(0, 5);
    pulse(34, 3);
    snap();
    drain(1'b0, -1, 1'b0);
    snap();
    drain(1'b0, -1, 1'b0);

    // Event coincident with the capture edge.
    pulse(7, 2);
    evt_stb[7] = 1'b1;
    snap_req = 1'b1;
    tick();
    evt_stb = '0;
    snap_req = 1'b0;
    drain(1'b0, -1, 1'b0);
    snap();
    drain(1'b0, -1, 1'b0);

    // Backpressure with mixed random events.
    for (int k = 0; k < 30; k++) begin
      evt_stb = {$urandom, $urandom};
      tick();
    end
    evt_stb = '0;
    snap();
    drain(1'b1, -1, 1'b0);

    // Dropped request mid-drain, then a back-to-back request on the last beat.
    pulse(12, 4);
    snap();
    drain(1'b0, 10, 1'b0);
    pulse(20, 6);
    snap();
    pulse(21, 2);
    drain(1'b0, -1, 1'b1);
    drain(1'b0, -1, 1'b0);

    // Saturation of the 4-bit instance, then cleared by the next snapshot.
    pulse(3, 20);
    snap();
    drain(1'b0, -1, 1'b0);
    snap();
    drain(1'b0, -1, 1'b0);

    // Asynchronous reset at beat 5 of a drain.
    pulse(9, 3);
    snap();
    for (int k = 0; k < 50 && q.size() > N - 5; k++) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", a_valid, 1'b0);
    chk("rst_mid_busy", a_busy, 1'b0);
    chk("rst_mid_last", a_last, 1'b0);
    clear_model();
    tick();
    rst = 1'b0;
    tick();
    snap();
    drain(1'b0, -1, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_xp10_decomp_blk_stats.md
# cr_xp10_decomp_blk_stats

Block-type and stall statistics collector downstream of the XP10 Huffman decode stage (htf + sdd). It accumulates the stage's single-cycle event strobes (block-format strobes, stall strobes, MTF strobes) into per-event saturating counters. On request it snapshots all counters into a shadow bank and streams them out over a valid/ready interface to the stats/register logic.

## Interface
Parameters:
- N_EVT, 35, number of event strobes; bit map below.
- CNT_W, 32, counter width.
- CLR_ON_SNAP, 1, 1 = live counters clear when a snapshot is taken; 0 = they keep running.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- evt_stb  in  N_EVT  event strobes, one cycle each, any combination per cycle.
  - Bits [1:0]: deflate dynamic/fixed.
  - Bits [25:2]: xp10, chu4k, chu8k, xp9 long/short blocks, in hufd port order.
  - Bits [30:26]: hdr_data, hdr_info, predef, input, buf_full stalls.
  - Bits [34:31]: mtf_stb[3:0].
- snap_req  in  1  snapshot request pulse.
- snap_busy  out  1  high from the snapshot cycle until the last beat is accepted.
- snap_drop  out  1  one-cycle pulse when snap_req is ignored because snap_busy is high.
- rd_valid  out  1  readout beat valid.
- rd_ready  in  1  readout beat accepted.
- rd_idx  out  clog2(N_EVT)  event index of the current beat.
- rd_cnt  out  CNT_W  snapshot count for rd_idx.
- rd_sat  out  1  counter rd_idx saturated during the snapshotted epoch.
- rd_last  out  1  high on the beat with rd_idx == N_EVT-1.

## Operation
- Live bank: N_EVT counters of CNT_W bits, plus one sticky saturation flag per counter.
  - Each cycle with evt_stb[i]=1, counter i increments by 1.
  - At all-ones the counter holds and sat[i] sets.
- Shadow bank: N_EVT × (CNT_W+1).
- FSM states:
  - IDLE: snap_req=1 → capture live counters and sat flags into the shadow bank, go to DRAIN with rd_idx=0.
  - DRAIN: present shadow[rd_idx]. On rd_valid && rd_ready:
    - rd_idx < N_EVT-1 → increment rd_idx.
    - rd_idx == N_EVT-1 → return to IDLE.
- snap_req while in DRAIN:
  - The request is ignored and the shadow is untouched.
  - snap_drop pulses the same cycle.
  - Live counters are not cleared.
- Clear behaviour:
  - CLR_ON_SNAP=1: live counters and sat flags clear on the capture edge. An evt_stb[i] in the capture cycle is not in the shadow; the live counter becomes 1.
  - CLR_ON_SNAP=0: the capture-cycle event is likewise excluded from the shadow and added to the live counter.
- Saturation is never cleared by readout, only by a snapshot with CLR_ON_SNAP=1 or by reset.
- rd_idx, rd_cnt, rd_sat and rd_last are held stable while rd_valid && !rd_ready.

## Timing
- Reset values:
  - All live counters, sat flags and shadow entries are 0.
  - FSM is in IDLE.
  - rd_valid, rd_last, snap_busy and snap_drop are 0.
  - rd_idx is 0.
- Counter update latency: 1 cycle (event at edge t is visible in the counter after edge t).
- snap_req sampled at edge t:
  - rd_valid=1, rd_idx=0 and snap_busy=1 from cycle t+1.
- Throughput: one beat per cycle with rd_ready held high, so a full drain is N_EVT cycles.
- The last beat is accepted at edge u: rd_valid=0 and snap_busy=0 from cycle u+1.
- A new snap_req at edge u itself is accepted: the FSM is in DRAIN but finishing, so the capture takes effect and DRAIN restarts at idx 0 in cycle u+1 with no idle gap.
- rst asserted mid-drain:
  - All state returns to reset values immediately (asynchronous).
  - The partial drain is abandoned and no rd_last is issued.
- Increment arithmetic is CNT_W-bit unsigned with no wrap; saturation at 2^CNT_W-1.

## Test plan
- Counting: pulse evt_stb[0] 5 times and evt_stb[34] 3 times, then snap_req → 35 beats.
  - idx0 cnt=5, idx34 cnt=3, all others 0; rd_last only on idx34.
  - Live counters are 0 afterwards (CLR_ON_SNAP=1).
- Coincident event: evt_stb[7]=1 in the same cycle as snap_req, with 2 prior events on bit 7.
  - Shadow idx7 reads 2.
  - A second snapshot reads idx7=1.
- Backpressure: toggle rd_ready 1/0 randomly during the drain.
  - Beats 0..34 arrive in order, none duplicated or skipped.
  - Outputs stay stable while stalled.
- Drop: snap_req at beat 10 of a drain → snap_drop pulses once and the drain completes unchanged.
  - snap_req in the cycle the last beat is accepted → a new drain starts at idx0 in the next cycle.
- Saturation (CNT_W=4): 20 pulses on bit 3 → idx3 cnt=15, rd_sat=1.
  - The next snapshot reads cnt=0, sat=0.
- Reset: assert rst at beat 5 → rd_valid and snap_busy drop in the same cycle.
  - After release, snap_req yields all counts 0.
